// File: rtl/score_engine.sv
// End-of-game scorer: clamps time/attempt overruns, weights them with a
// serial shift-add multiplier, sums with the level bonus and tracks best scores.
module score_engine #(
  parameter int NUM_LEVELS = 3,
  parameter int LVL_W      = 2,
  parameter int SEC_W      = 6,
  parameter int CARD_W     = 6,
  parameter int PAIR_W     = 8,
  parameter int SCORE_W    = 14,
  parameter int CAP        = 33,
  parameter int CAP_W      = 6,
  parameter int WEIGHT     = 101,
  parameter logic [NUM_LEVELS*SCORE_W-1:0] LVL_BONUS = {14'd3300, 14'd1600, 14'd0},
  parameter logic [NUM_LEVELS*SEC_W-1:0]   LVL_GRACE = {6'd10, 6'd5, 6'd0}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [LVL_W-1:0]   level,
  input  logic [CARD_W-1:0]  num_of_cards,
  input  logic [SEC_W-1:0]   seconds,
  input  logic [PAIR_W-1:0]  attempts,
  input  logic               clear_hiscore,
  input  logic [LVL_W-1:0]   hiscore_sel,
  output logic               busy,
  output logic               done,
  output logic               new_record,
  output logic [SCORE_W-1:0] points,
  output logic [SCORE_W-1:0] hiscore
);

  // state   | meaning
  // IDLE    | waiting for start; clear_hiscore honoured here only
  // CLAMP   | derive clamped time and attempt overruns
  // MUL_T   | shift-add WEIGHT*tm over CAP_W cycles
  // MUL_P   | shift-add WEIGHT*pm over CAP_W cycles
  // SUM     | bonus plus both partial scores, saturated
  // DONE    | publish points, update best-score table
  typedef enum logic [2:0] {S_IDLE, S_CLAMP, S_MUL_T, S_MUL_P, S_SUM, S_DONE} state_t;

  localparam int PART_MAX = CAP * WEIGHT;
  localparam int SUM_W    = SCORE_W + 2;

  state_t              state_q, state_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic [CARD_W-1:0]   cards_q, cards_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [PAIR_W-1:0]   att_q, att_d;
  logic [CAP_W-1:0]    pm_q, pm_d, mplier_q, mplier_d, cnt_q, cnt_d;
  logic [SCORE_W-1:0]  shift_q, shift_d, acc_q, acc_d;
  logic [SCORE_W-1:0]  tp_q, tp_d, pp_q, pp_d, sum_q, sum_d;
  logic [SCORE_W-1:0]  points_q, points_d;
  logic                done_q, done_d, new_record_q, new_record_d;
  logic [SCORE_W-1:0]  table_q [NUM_LEVELS];
  logic [SCORE_W-1:0]  table_d [NUM_LEVELS];

  logic [SCORE_W-1:0]  bonus, best, prod_step, sum_sat;
  logic [SEC_W-1:0]    grace;
  logic [SEC_W:0]      t_diff;
  logic [PAIR_W:0]     p_diff, att_w, half_w;
  logic [CAP_W-1:0]    tm, pm;
  logic [SUM_W-1:0]    sum_w;

  always_comb begin
    bonus = '0;
    grace = '0;
    best  = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (lvl_q == LVL_W'(i)) begin
        bonus = LVL_BONUS[i*SCORE_W +: SCORE_W];
        grace = LVL_GRACE[i*SEC_W +: SEC_W];
        best  = table_q[i];
      end
    end
  end

  always_comb begin
    hiscore = '0;
    for (int i = 0; i < NUM_LEVELS; i++)
      if (hiscore_sel == LVL_W'(i)) hiscore = table_q[i];
  end

  // Overruns are computed one bit wider than their operands so they never wrap.
  always_comb begin
    t_diff = {1'b0, sec_q} - {1'b0, grace};
    if (sec_q <= grace)                    tm = '0;
    else if (t_diff > (SEC_W+1)'(CAP))     tm = CAP_W'(CAP);
    else                                   tm = CAP_W'(t_diff);
    att_w  = (PAIR_W+1)'(att_q);
    half_w = (PAIR_W+1)'(cards_q >> 1);
    p_diff = att_w - half_w;
    if (att_w <= half_w)                   pm = '0;
    else if (p_diff > (PAIR_W+1)'(CAP))    pm = CAP_W'(CAP);
    else                                   pm = CAP_W'(p_diff);
  end

  assign prod_step = acc_q + (mplier_q[0] ? shift_q : '0);
  assign sum_w = SUM_W'(bonus) + SUM_W'(PART_MAX) - SUM_W'(tp_q)
               + SUM_W'(PART_MAX) - SUM_W'(pp_q);
  assign sum_sat = (|sum_w[SUM_W-1:SCORE_W]) ? '1 : sum_w[SCORE_W-1:0];

  always_comb begin
    state_d      = state_q;
    lvl_d        = lvl_q;
    cards_d      = cards_q;
    sec_d        = sec_q;
    att_d        = att_q;
    pm_d         = pm_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    tp_d         = tp_q;
    pp_d         = pp_q;
    sum_d        = sum_q;
    points_d     = points_q;
    done_d       = 1'b0;
    new_record_d = 1'b0;
    table_d      = table_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lvl_d   = (int'(level) >= NUM_LEVELS) ? '0 : level;
          cards_d = num_of_cards;
          sec_d   = seconds;
          att_d   = attempts;
          state_d = S_CLAMP;
        end else if (clear_hiscore) begin
          for (int i = 0; i < NUM_LEVELS; i++) table_d[i] = '0;
        end
      end
      S_CLAMP: begin
        mplier_d = tm;
        pm_d     = pm;
        shift_d  = SCORE_W'(WEIGHT);
        acc_d    = '0;
        cnt_d    = CAP_W'(CAP_W - 1);
        state_d  = S_MUL_T;
      end
      S_MUL_T, S_MUL_P: begin
        acc_d    = prod_step;
        mplier_d = mplier_q >> 1;
        shift_d  = shift_q << 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Reload the multiplier for the attempt product, or move on to SUM.
          mplier_d = pm_q;
          shift_d  = SCORE_W'(WEIGHT);
          acc_d    = '0;
          cnt_d    = CAP_W'(CAP_W - 1);
          if (state_q == S_MUL_T) begin
            tp_d    = prod_step;
            state_d = S_MUL_P;
          end else begin
            pp_d    = prod_step;
            state_d = S_SUM;
          end
        end
      end
      S_SUM: begin
        sum_d   = sum_sat;
        state_d = S_DONE;
      end
      S_DONE: begin
        points_d = sum_q;
        done_d   = 1'b1;
        if (sum_q > best) begin
          new_record_d = 1'b1;
          for (int i = 0; i < NUM_LEVELS; i++)
            if (lvl_q == LVL_W'(i)) table_d[i] = sum_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && abort) begin
      state_d      = S_IDLE;
      points_d     = points_q;
      done_d       = 1'b0;
      new_record_d = 1'b0;
      table_d      = table_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lvl_q        <= '0;
      cards_q      <= '0;
      sec_q        <= '0;
      att_q        <= '0;
      pm_q         <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      acc_q        <= '0;
      tp_q         <= '0;
      pp_q         <= '0;
      sum_q        <= '0;
      points_q     <= '0;
      done_q       <= 1'b0;
      new_record_q <= 1'b0;
      for (int i = 0; i < NUM_LEVELS; i++) table_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      lvl_q        <= lvl_d;
      cards_q      <= cards_d;
      sec_q        <= sec_d;
      att_q        <= att_d;
      pm_q         <= pm_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      tp_q         <= tp_d;
      pp_q         <= pp_d;
      sum_q        <= sum_d;
      points_q     <= points_d;
      done_q       <= done_d;
      new_record_q <= new_record_d;
      for (int i = 0; i < NUM_LEVELS; i++) table_q[i] <= table_d[i];
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign new_record = new_record_q;
  assign points     = points_q;

endmodule

// File: tb/tb_score_engine.sv
// Bench for score_engine: cycle-level reference model checked every negedge,
// plus directed games with hand-computed scores and latencies.
module tb_score_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, clear_hiscore = 1'b0;
  logic [1:0]  level = '0, hiscore_sel = '0;
  logic [5:0]  num_of_cards = '0, seconds = '0;
  logic [7:0]  attempts = '0;
  logic        busy, done, new_record;
  logic [13:0] points, hiscore;

  int checks_total = 0;
  int checks_pass  = 0;
  bit sel_auto = 1'b1;

  score_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .level(level),
    .num_of_cards(num_of_cards), .seconds(seconds), .attempts(attempts),
    .clear_hiscore(clear_hiscore), .hiscore_sel(hiscore_sel),
    .busy(busy), .done(done), .new_record(new_record),
    .points(points), .hiscore(hiscore)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int score(input int lv, input int cr, input int sc, input int at);
    int l, g, b, tm, pm, s;
    l  = (lv >= 3) ? 0 : lv;
    g  = (l == 2) ? 10 : (l == 1) ? 5 : 0;
    b  = (l == 2) ? 3300 : (l == 1) ? 1600 : 0;
    tm = (sc <= g) ? 0 : ((sc - g > 33) ? 33 : sc - g);
    pm = (at <= cr / 2) ? 0 : ((at - cr / 2 > 33) ? 33 : at - cr / 2);
    s  = b + (3333 - 101 * tm) + (3333 - 101 * pm);
    return (s > 16383) ? 16383 : s;
  endfunction

  // Reference model: a game is a 15-cycle countdown from the start edge.
  int m_table [3];
  int m_left, m_result, m_points, m_lvl;
  bit m_done, m_new;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0; m_points = 0; m_done = 0; m_new = 0; m_lvl = 0;
      for (int i = 0; i < 3; i++) m_table[i] = 0;
    end else begin
      m_done = 0;
      m_new  = 0;
      if (m_left == 0) begin
        if (start) begin
          m_lvl    = (level >= 3) ? 0 : int'(level);
          m_result = score(level, num_of_cards, seconds, attempts);
          m_left   = 15;
        end else if (clear_hiscore) begin
          for (int i = 0; i < 3; i++) m_table[i] = 0;
        end
      end else if (abort) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done   = 1;
          m_points = m_result;
          if (m_result > m_table[m_lvl]) begin
            m_table[m_lvl] = m_result;
            m_new = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, (m_left != 0) ? 1 : 0);
    check("done", done, m_done);
    check("new_record", new_record, m_new);
    check("points", points, m_points);
    check("hiscore", hiscore, (hiscore_sel < 3) ? m_table[hiscore_sel] : 0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
    if (sel_auto) hiscore_sel = (hiscore_sel == 2'd2) ? 2'd0 : hiscore_sel + 2'd1;
  endtask

  task automatic pulse_start(input int lv, input int cr, input int sc, input int at);
    level = 2'(lv); num_of_cards = 6'(cr); seconds = 6'(sc); attempts = 8'(at);
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0; clear_hiscore = 1'b0;
    level = 2'($urandom_range(0, 3));
    num_of_cards = 6'($urandom_range(0, 63));
    seconds = 6'($urandom_range(0, 63));
    attempts = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(input int poke_at, output int lat, output int pts, output int nr);
    lat = -1; pts = -1; nr = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      start = 1'b0;
      if (done) begin
        lat = n; pts = points; nr = new_record;
        break;
      end
      if (n == poke_at) start = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic game(input string name, input int lv, input int cr, input int sc,
                      input int at, input int poke_at, input int exp_pts, input int exp_nr);
    int lat, pts, nr;
    pulse_start(lv, cr, sc, at);
    wait_done(poke_at, lat, pts, nr);
    check({name, " latency"}, lat, 15);
    check({name, " points"}, pts, exp_pts);
    check({name, " new_record"}, nr, exp_nr);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset points", points, 0);
    check("reset hiscore", hiscore, 0);
    rst = 1'b1;
    tick();

    game("case1", 0, 12, 10, 6, 0, 5656, 1);
    game("case2", 2, 24, 8, 20, 0, 9158, 1);
    game("case3 clamp", 0, 12, 63, 255, 0, 0, 0);
    game("case4 tie", 0, 12, 10, 6, 5, 5656, 0);

    pulse_start(1, 12, 20, 10);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort points", points, 5656);
    check("abort done", done, 0);
    game("after abort", 1, 12, 20, 10, 0, 6347, 1);

    abort = 1'b1;
    game("start beats abort lvl3", 3, 10, 40, 7, 0, 3131, 0);

    pulse_start(2, 24, 8, 20);
    repeat (9) tick();
    rst = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst new_record", new_record, 0);
    check("midrst points", points, 0);
    check("midrst hiscore", hiscore, 0);
    tick();
    rst = 1'b1;
    tick();

    game("refill lvl2", 2, 24, 8, 20, 0, 9158, 1);
    clear_hiscore = 1'b1;
    game("start beats clear", 0, 12, 10, 6, 0, 5656, 1);
    sel_auto = 1'b0;
    hiscore_sel = 2'd2;
    #1;
    check("hiscore2 kept", hiscore, 9158);
    hiscore_sel = 2'd0;
    #1;
    check("hiscore0 set", hiscore, 5656);
    clear_hiscore = 1'b1;
    tick();
    clear_hiscore = 1'b0;
    for (int s = 0; s < 3; s++) begin
      hiscore_sel = 2'(s);
      #1;
      check("cleared hiscore", hiscore, 0);
    end
    tick();
    tick();

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
